pc_fetch_stage: RTL



---
 rtl/pc_fetch_stage_if.sv | 31 +++
 rtl/pc_fetch_stage.sv | 106 ++++++++++
 2 files changed

// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, PC and IF/ID payload out,
// plus the ADD4 and instruction-memory hookups.
interface pc_fetch_stage_if #(
  parameter int unsigned IM_AW = 10
);
  logic              stall;
  logic [1:0]        npc_sel;
  logic              branch_taken;
  logic [31:0]       rs_fwd_D;
  logic [31:0]       pc_add4_F;
  logic [31:0]       pc_F;
  logic [IM_AW-1:0]  imem_addr;
  logic [31:0]       imem_rdata;
  logic [31:0]       instr_D;
  logic [31:0]       pc_D;
  logic [31:0]       pc8_D;
  logic              valid_D;
  logic              fetch_fault;

  // Fetch stage side
  modport master (
    input  stall, npc_sel, branch_taken, rs_fwd_D, pc_add4_F, imem_rdata,
    output pc_F, imem_addr, instr_D, pc_D, pc8_D, valid_D, fetch_fault
  );

  // Surrounding pipeline / memory side
  modport slave (
    output stall, npc_sel, branch_taken, rs_fwd_D, pc_add4_F, imem_rdata,
    input  pc_F, imem_addr, instr_D, pc_D, pc8_D, valid_D, fetch_fault
  );
endinterface

// File: rtl/pc_fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC selection and the IF/ID
// pipeline register. Redirects resolve in D with one delay slot (no flush).
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  pc_fetch_stage_if.master      bus
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    NPC_ADD4   = 2'b00,
    NPC_BRANCH = 2'b01,
    NPC_JUMP   = 2'b10,
    NPC_JR     = 2'b11
  } npc_sel_e;

  logic [XLEN-1:0] pc_q,    pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pcd_q,   pcd_d;
  logic [XLEN-1:0] pc8_q,   pc8_d;
  logic            valid_q, valid_d;

  logic [XLEN-1:0] offset_c;
  logic [XLEN-1:0] word_idx_c;
  logic            fault_c;
  logic [XLEN-1:0] br_off_c;
  logic [XLEN-1:0] br_tgt_c;
  logic [XLEN-1:0] j_tgt_c;
  logic [XLEN-1:0] npc_c;
  npc_sel_e        sel_c;

  // Instruction-memory address and fault detection from the current fetch PC
  always_comb begin
    offset_c   = pc_q - IM_BASE;
    word_idx_c = offset_c >> 2;
    fault_c    = (pc_q[1:0] != 2'b00)
               || (pc_q < IM_BASE)
               || ((word_idx_c >> IM_AW) != '0);
  end

  // Redirect targets are relative to the instruction sitting in D
  always_comb begin
    br_off_c = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    br_tgt_c = pcd_q + XLEN'(4) + br_off_c;
    j_tgt_c  = {pcd_q[31:28], instr_q[25:0], 2'b00};
  end

  // Next-PC mux
  always_comb begin
    sel_c = npc_sel_e'(bus.npc_sel);
    npc_c = bus.pc_add4_F;
    unique case (sel_c)
      NPC_ADD4:   npc_c = bus.pc_add4_F;
      NPC_BRANCH: npc_c = bus.branch_taken ? br_tgt_c : bus.pc_add4_F;
      NPC_JUMP:   npc_c = j_tgt_c;
      NPC_JR:     npc_c = bus.rs_fwd_D;
      default:    npc_c = bus.pc_add4_F;
    endcase
  end

  // Next-state: hold everything on stall, otherwise advance PC and IF/ID
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pcd_d   = pcd_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    if (!bus.stall) begin
      pc_d    = npc_c;
      instr_d = fault_c ? '0 : bus.imem_rdata;
      pcd_d   = pc_q;
      pc8_d   = pc_q + XLEN'(8);
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pcd_q   <= '0;
      pc8_q   <= XLEN'(8);
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pcd_q   <= pcd_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc_F        = pc_q;
  assign bus.imem_addr   = word_idx_c[IM_AW-1:0];
  assign bus.fetch_fault = fault_c;
  assign bus.instr_D     = instr_q;
  assign bus.pc_D        = pcd_q;
  assign bus.pc8_D       = pc8_q;
  assign bus.valid_D     = valid_q;

endmodule
